// File: rtl/car_motion_update_if.sv
// rtl/car_motion_update_if.sv - Frame, load, velocity and collision-result bundle for car_motion_update
interface car_motion_update_if #(
  parameter int X_WIDTH = 12,
  parameter int Y_WIDTH = 11,
  parameter int V_INT   = 4,
  parameter int V_FRAC  = 8
) ();
  logic                             i_frame_tick;
  logic                             i_load;
  logic signed [X_WIDTH-1:0]        i_load_x;
  logic signed [Y_WIDTH-1:0]        i_load_y;
  logic signed [V_INT+V_FRAC-1:0]   i_cmd_v_x;
  logic signed [V_INT+V_FRAC-1:0]   i_cmd_v_y;
  logic signed [V_INT+V_FRAC-1:0]   i_col_v_x;
  logic signed [V_INT+V_FRAC-1:0]   i_col_v_y;
  logic                             i_in_sand;
  logic                             i_in_rock;
  logic                             i_in_track0;
  logic                             i_in_track1;
  logic                             i_collision;
  logic signed [X_WIDTH-1:0]        o_x;
  logic signed [Y_WIDTH-1:0]        o_y;
  logic signed [V_INT+V_FRAC-1:0]   o_v_x;
  logic signed [V_INT+V_FRAC-1:0]   o_v_y;
  logic [3:0]                       o_lap_count;
  logic                             o_hit;
  logic                             o_busy;
  logic                             o_update_done;

  modport master (
    output i_frame_tick, i_load, i_load_x, i_load_y, i_cmd_v_x, i_cmd_v_y,
           i_col_v_x, i_col_v_y, i_in_sand, i_in_rock, i_in_track0, i_in_track1,
           i_collision,
    input  o_x, o_y, o_v_x, o_v_y, o_lap_count, o_hit, o_busy, o_update_done
  );

  modport slave (
    input  i_frame_tick, i_load, i_load_x, i_load_y, i_cmd_v_x, i_cmd_v_y,
           i_col_v_x, i_col_v_y, i_in_sand, i_in_rock, i_in_track0, i_in_track1,
           i_collision,
    output o_x, o_y, o_v_x, o_v_y, o_lap_count, o_hit, o_busy, o_update_done
  );
endinterface

// File: rtl/car_motion_update.sv
// rtl/car_motion_update.sv - Per-frame car kinematics: friction, fixed-point integration, map clamp, lap count
module car_motion_update #(
  parameter int X_WIDTH = 12,
  parameter int Y_WIDTH = 11,
  parameter int V_INT   = 4,
  parameter int V_FRAC  = 8,
  parameter int X_MIN   = -780,
  parameter int X_MAX   = 780,
  parameter int Y_MIN   = -380,
  parameter int Y_MAX   = 380,
  parameter int START_X = 0,
  parameter int START_Y = -307,
  parameter int LAP_MAX = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  car_motion_update_if.slave  bus
);
  localparam int XW       = X_WIDTH + V_FRAC;
  localparam int YW       = Y_WIDTH + V_FRAC;
  localparam int VW       = V_INT + V_FRAC;
  localparam int FRAC_ONE = 1 << V_FRAC;

  // Bounds carry one extra bit so the raw sum can be compared before truncation.
  localparam logic signed [XW:0]   X_HI  = (XW+1)'(X_MAX * FRAC_ONE);
  localparam logic signed [XW:0]   X_LO  = (XW+1)'(X_MIN * FRAC_ONE);
  localparam logic signed [YW:0]   Y_HI  = (YW+1)'(Y_MAX * FRAC_ONE);
  localparam logic signed [YW:0]   Y_LO  = (YW+1)'(Y_MIN * FRAC_ONE);
  localparam logic signed [XW-1:0] X_RST = XW'(START_X * FRAC_ONE);
  localparam logic signed [YW-1:0] Y_RST = YW'(START_Y * FRAC_ONE);
  localparam logic [3:0]           LAP_SAT = 4'(LAP_MAX);

  typedef enum logic [1:0] {IDLE, SETTLE, RESOLVE, MOVE} state_t;

  state_t                state;
  logic signed [XW-1:0]  pos_x;
  logic signed [YW-1:0]  pos_y;
  logic signed [VW-1:0]  v_x;
  logic signed [VW-1:0]  v_y;
  logic [3:0]            lap_count;
  logic                  hit;
  logic                  busy;
  logic                  update_done;
  logic                  checkpoint;
  logic                  prev_track0;

  logic signed [XW:0]    sum_x;
  logic signed [YW:0]    sum_y;
  logic signed [XW-1:0]  next_x;
  logic signed [YW-1:0]  next_y;
  logic signed [VW-1:0]  fric_x;
  logic signed [VW-1:0]  fric_y;
  logic                  lap_event;

  // Sand halves speed and dominates rock, which removes a quarter.
  function automatic logic signed [VW-1:0] apply_friction(
    input logic signed [VW-1:0] v,
    input logic                 sand,
    input logic                 rock
  );
    logic signed [VW-1:0] r;
    if (sand)      r = v >>> 1;
    else if (rock) r = v - (v >>> 2);
    else           r = v;
    return r;
  endfunction

  assign fric_x    = apply_friction(bus.i_col_v_x, bus.i_in_sand, bus.i_in_rock);
  assign fric_y    = apply_friction(bus.i_col_v_y, bus.i_in_sand, bus.i_in_rock);
  assign lap_event = prev_track0 & bus.i_in_track1 & checkpoint;

  assign sum_x = (XW+1)'(pos_x) + (XW+1)'(v_x);
  assign sum_y = (YW+1)'(pos_y) + (YW+1)'(v_y);

  // Clamp the integrated position; a clamped axis lands exactly on the bound with no fraction.
  always_comb begin
    next_x = sum_x[XW-1:0];
    next_y = sum_y[YW-1:0];
    if (sum_x > X_HI)      next_x = X_HI[XW-1:0];
    else if (sum_x < X_LO) next_x = X_LO[XW-1:0];
    if (sum_y > Y_HI)      next_y = Y_HI[YW-1:0];
    else if (sum_y < Y_LO) next_y = Y_LO[YW-1:0];
  end

  // Update sequencer: command latch, collision settle, resolve/friction/laps, position commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      pos_x       <= X_RST;
      pos_y       <= Y_RST;
      v_x         <= '0;
      v_y         <= '0;
      lap_count   <= '0;
      hit         <= 1'b0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      checkpoint  <= 1'b0;
      prev_track0 <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_frame_tick) begin
            v_x   <= bus.i_cmd_v_x;
            v_y   <= bus.i_cmd_v_y;
            busy  <= 1'b1;
            state <= SETTLE;
          end else if (bus.i_load) begin
            pos_x <= {bus.i_load_x, {V_FRAC{1'b0}}};
            pos_y <= {bus.i_load_y, {V_FRAC{1'b0}}};
            v_x   <= '0;
            v_y   <= '0;
          end
        end
        SETTLE: begin
          state <= RESOLVE;
        end
        RESOLVE: begin
          v_x         <= fric_x;
          v_y         <= fric_y;
          hit         <= bus.i_collision;
          prev_track0 <= bus.i_in_track0;
          if (lap_event) begin
            if (lap_count != LAP_SAT) lap_count <= lap_count + 4'd1;
            checkpoint <= 1'b0;
          end else if (bus.i_in_rock) begin
            checkpoint <= 1'b1;
          end
          state <= MOVE;
        end
        MOVE: begin
          pos_x       <= next_x;
          pos_y       <= next_y;
          busy        <= 1'b0;
          update_done <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_x           = pos_x[XW-1:V_FRAC];
  assign bus.o_y           = pos_y[YW-1:V_FRAC];
  assign bus.o_v_x         = v_x;
  assign bus.o_v_y         = v_y;
  assign bus.o_lap_count   = lap_count;
  assign bus.o_hit         = hit;
  assign bus.o_busy        = busy;
  assign bus.o_update_done = update_done;
endmodule
